ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX/MEM pipeline stage with a valid/ready handshake, a one-entry skid buffer and a synchronous flush. It sits between the execute and memory stages of the MIPS pipeline. It carries the stage's control bits (branch, memory read/write, memtoreg, regwrite), PC, zero flag, ALU result, store data and destination register. It lets the memory stage back-pressure execute without a combinational ready path. A flush turns every buffered entry into a bubble so that a taken branch can squash wrong-path work.

## Interface
- DATA_W, 32, width of alu_result and store_data
- PC_W, 32, width of the PC field
- REG_AW, 5, width of the destination register index
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash all buffered entries (synchronous)
- in_valid  in  1  execute presents a beat
- in_ready  out  1  stage can accept a beat
- in_branch, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write  in  1 each  control bits
- in_pc  in  PC_W  PC of the instruction
- in_zero  in  1  ALU zero flag
- in_alu_result  in  DATA_W  ALU result / memory address
- in_store_data  in  DATA_W  data to write to data memory
- in_dest_reg  in  REG_AW  rt/rd destination index
- out_valid  out  1  stage presents a beat to memory
- out_ready  in  1  memory stage accepts the beat
- out_* (same 10 fields)  out  same widths  registered copies of the in_* fields
- stall_cnt  out  16  present only with EX_MEM_STALL_CNT_EN

## Operation
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Storage: main register (drives out_*) plus skid register, each with its own valid bit.
- States, derived from the two valid bits:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Transitions:
  - EMPTY + input transfer: main loads the input, go to ONE.
  - ONE, input transfer and out_ready: main loads the input, stay in ONE.
  - ONE, input transfer and !out_ready: skid loads the input, go to FULL.
  - ONE, no input transfer and out_ready: go to EMPTY.
  - ONE, neither: hold.
  - FULL + out_ready: main loads skid, skid is invalidated, go to ONE. in_ready is 0 in FULL, so there is no input transfer.
- Bubble gating: out_branch, out_mem_read, out_mem_write, out_mem_to_reg and out_reg_write are forced to 0 whenever out_valid = 0. Data fields are not gated.
- Flush:
  - Next state is EMPTY. Both valid bits and all stored control bits are cleared.
  - Stored data fields hold their values.
  - Flush overrides a simultaneous input transfer; that beat is dropped.
  - Flush does not depend on out_ready.
- Order is preserved: a skid entry is always older than any later input.

## Timing
- Reset (asynchronous assert):
  - Main and skid valid bits, all stored fields and stall_cnt go to 0.
  - Outputs: out_valid = 0, in_ready = 1, all out_* = 0.
- Reset release: the first input transfer can occur on the first rising edge.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready = 1.
- Back-pressure: with out_ready low, exactly one more beat is accepted, after which in_ready falls on the next edge.
- Recovery: when out_ready rises in FULL, in_ready returns high one cycle later.
- Reset mid-operation discards all entries immediately.
- flush and rst are both level, single-cycle effective. A flush held for N cycles keeps the stage EMPTY for N cycles.

## Configuration
- EX_MEM_STALL_CNT_EN defined:
  - stall_cnt counts cycles with out_valid && !out_ready.
  - It saturates at 16'hFFFF and clears only on rst.
  - Flush does not clear it.
- EX_MEM_STALL_CNT_EN undefined: the stall_cnt port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - typedef ex_mem_ctrl_t: packed struct of the five control bits.
  - localparam CTRL_W = 5.
  - localparam STALL_CNT_W = 16.
- Sub-module pipe_skid_buf: generic two-entry valid/ready skid buffer, parametrised by payload width, with a clear input. ex_mem_stage packs the fields into a payload, instantiates pipe_skid_buf, and adds the bubble gating and the optional counter.

## Test plan
- Reset:
  - Hold rst with in_valid = 1 → out_valid = 0, in_ready = 1, out_alu_result = 0.
  - Release rst, drive alu_result = 8'h2A, dest_reg = 5'd9 → next edge gives out_valid = 1, out_alu_result = 8'h2A, out_dest_reg = 9.
- Streaming: 10 back-to-back beats with out_ready = 1 → outputs appear in order, 1-cycle latency, in_ready stays 1.
- Back-pressure: drop out_ready with beats A, B, C queued → A held on output, B captured in skid, in_ready = 0, C not accepted. Raise out_ready → outputs A, B, C in order, none lost or duplicated.
- Flush:
  - Assert flush in FULL with in_valid = 1 → next cycle out_valid = 0, out_reg_write = 0, out_mem_write = 0, in_ready = 1, incoming beat dropped.
  - Next beat after the flush flows normally.
- Bubble gating: present a beat with mem_write = 1 then idle → out_mem_write = 0 on every cycle where out_valid = 0.
- Stall counter (EX_MEM_STALL_CNT_EN only):
  - out_valid held with out_ready = 0 for 7 cycles → stall_cnt = 7.
  - Preload near 16'hFFFF → stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit struct and widths for the pipeline stage registers.
package pipe_pkg;
   localparam int CTRL_W = 5;
   localparam int STALL_CNT_W = 16;
   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ex_mem_ctrl_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready skid buffer; in_ready is registered (!skid_valid).
// clr empties the buffer and zeroes the payload bits selected by CLR_MASK.
module pipe_skid_buf #(
   parameter int W = 8,
   parameter logic [W-1:0] CLR_MASK = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         main_valid, skid_valid;
   logic [W-1:0] main_data, skid_data;
   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (clr) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= main_data & ~CLR_MASK;
         skid_data  <= skid_data & ~CLR_MASK;
      end else if (skid_valid) begin
         if (out_ready) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end
      end else if (!main_valid || out_ready) begin
         // empty, or main drains this cycle: input goes straight to main
         main_valid <= in_valid;
         if (in_valid) main_data <= in_data;
      end else if (in_valid) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register on a skid buffer with flush and bubble gating.
// Optional EX_MEM_STALL_CNT_EN adds a saturating stall_cnt output.
module ex_mem_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
`ifdef EX_MEM_STALL_CNT_EN
   output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_branch,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_mem_to_reg,
   input  logic              in_reg_write,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_zero,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [REG_AW-1:0] in_dest_reg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_branch,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_mem_to_reg,
   output logic              out_reg_write,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_zero,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [REG_AW-1:0] out_dest_reg
);
   localparam int PW = PC_W + 1 + 2 * DATA_W + REG_AW + CTRL_W;
   localparam logic [PW-1:0] CTRL_MASK = {{(PW - CTRL_W){1'b0}}, {CTRL_W{1'b1}}};
   ex_mem_ctrl_t in_ctrl, out_ctrl;
   logic [PW-1:0] in_pl, out_pl;
   assign in_ctrl = {in_branch, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write};
   assign in_pl   = {in_pc, in_zero, in_alu_result, in_store_data, in_dest_reg, in_ctrl};
   assign {out_pc, out_zero, out_alu_result, out_store_data, out_dest_reg, out_ctrl} = out_pl;
   pipe_skid_buf #(.W(PW), .CLR_MASK(CTRL_MASK)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pl)
   );
   // control bits become a bubble whenever nothing valid is presented
   assign out_branch     = out_ctrl.branch     & out_valid;
   assign out_mem_read   = out_ctrl.mem_read   & out_valid;
   assign out_mem_write  = out_ctrl.mem_write  & out_valid;
   assign out_mem_to_reg = out_ctrl.mem_to_reg & out_valid;
   assign out_reg_write  = out_ctrl.reg_write  & out_valid;
`ifdef EX_MEM_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage; queue model of the two-entry stage.
module tb_ex_mem_stage;
   typedef struct packed {
      logic [31:0] pc;
      logic        zero;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  dest;
      logic [4:0]  ctrl;
   } beat_t;

   logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid;
   logic out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_zero;
   logic [31:0] out_pc, out_alu_result, out_store_data;
   logic [4:0]  out_dest_reg;
   beat_t cur = '0;
   beat_t q[$];
   int checks = 0, errors = 0;
   logic [15:0] sc = '0;
`ifdef EX_MEM_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
`ifdef EX_MEM_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .in_valid(in_valid), .in_ready(in_ready),
      .in_branch(cur.ctrl[4]), .in_mem_read(cur.ctrl[3]), .in_mem_write(cur.ctrl[2]),
      .in_mem_to_reg(cur.ctrl[1]), .in_reg_write(cur.ctrl[0]),
      .in_pc(cur.pc), .in_zero(cur.zero), .in_alu_result(cur.alu),
      .in_store_data(cur.sd), .in_dest_reg(cur.dest),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
      .out_pc(out_pc), .out_zero(out_zero), .out_alu_result(out_alu_result),
      .out_store_data(out_store_data), .out_dest_reg(out_dest_reg)
   );

   function automatic beat_t rnd();
      beat_t b;
      b.pc   = $urandom;
      b.zero = 1'($urandom_range(0, 1));
      b.alu  = $urandom;
      b.sd   = $urandom;
      b.dest = 5'($urandom_range(0, 31));
      b.ctrl = 5'($urandom_range(0, 31));
      return b;
   endfunction

   // check current outputs against the model, advance the model, then clock once
   task automatic step();
      beat_t obs;
      int n;
      n = q.size();
      obs = {out_pc, out_zero, out_alu_result, out_store_data, out_dest_reg,
             out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write};
      checks++;
      if (in_ready !== (n < 2)) begin
         errors++;
         $display("FAIL in_ready: got %b want %b", in_ready, n < 2);
      end
      checks++;
      if (out_valid !== (n > 0)) begin
         errors++;
         $display("FAIL out_valid: got %b want %b", out_valid, n > 0);
      end
      checks++;
      if (n > 0) begin
         if (obs !== q[0]) begin
            errors++;
            $display("FAIL out_beat: got %h want %h", obs, q[0]);
         end
      end else if (obs.ctrl !== 5'b0) begin
         errors++;
         $display("FAIL bubble_ctrl: got %b want 00000", obs.ctrl);
      end
`ifdef EX_MEM_STALL_CNT_EN
      checks++;
      if (stall_cnt !== sc) begin
         errors++;
         $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, sc);
      end
`endif
      if (n > 0 && !out_ready && sc != 16'hFFFF) sc++;
      if (flush) q.delete();
      else begin
         if (n > 0 && out_ready) void'(q.pop_front());
         if (in_valid && n < 2) q.push_back(cur);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1;
      #2;
      rst = 0;
      q.delete();
      sc = '0;
   endtask

   task automatic test_reset();
      rst = 1;
      in_valid = 1;
      cur = rnd();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (out_alu_result !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", out_alu_result); end
      checks++;
      if (out_dest_reg !== 5'd0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_fields: got dest %0d pc %h want 0", out_dest_reg, out_pc);
      end
      cur.alu = 32'h2A;
      cur.dest = 5'd9;
      out_ready = 1;
      rst = 0;
      step();
      in_valid = 0;
      checks++;
      if (out_alu_result !== 32'h2A || out_dest_reg !== 5'd9) begin
         errors++;
         $display("FAIL first_beat: got alu %h dest %0d want 2a 9", out_alu_result, out_dest_reg);
      end
      step();
      step();
   endtask

   task automatic test_streaming();
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         cur = rnd();
         in_valid = 1;
         step();
      end
      in_valid = 0;
      step();
      step();
   endtask

   task automatic test_back_pressure();
      out_ready = 0;
      in_valid = 1;
      repeat (3) begin
         cur = rnd();
         step();
      end
      step();
      out_ready = 1;
      step();
      step();
      in_valid = 0;
      step();
      step();
   endtask

   task automatic test_flush();
      out_ready = 0;
      in_valid = 1;
      repeat (2) begin
         cur = rnd();
         cur.ctrl = 5'b11111;
         step();
      end
      cur = rnd();
      flush = 1;
      step();
      flush = 0;
      in_valid = 0;
      step();
      out_ready = 1;
      cur = rnd();
      in_valid = 1;
      step();
      in_valid = 0;
      step();
      in_valid = 1;
      flush = 1;
      repeat (3) begin
         cur = rnd();
         step();
      end
      flush = 0;
      in_valid = 0;
      step();
      step();
   endtask

   task automatic test_bubble();
      out_ready = 1;
      cur = rnd();
      cur.ctrl[2] = 1'b1;
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (3) step();
   endtask

   task automatic test_mid_reset();
      out_ready = 0;
      in_valid = 1;
      repeat (2) begin
         cur = rnd();
         step();
      end
      in_valid = 0;
      pulse_reset();
      step();
      out_ready = 1;
      cur = rnd();
      in_valid = 1;
      step();
      in_valid = 0;
      step();
      step();
   endtask

`ifdef EX_MEM_STALL_CNT_EN
   task automatic test_stall_cnt();
      pulse_reset();
      out_ready = 0;
      cur = rnd();
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (7) step();
      checks++;
      if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stall_7: got %0d want 7", stall_cnt); end
      flush = 1;
      step();
      flush = 0;
      checks++;
      if (stall_cnt !== 16'd8) begin errors++; $display("FAIL stall_after_flush: got %0d want 8", stall_cnt); end
      cur = rnd();
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (65540) @(posedge clk);
      #1;
      sc = 16'hFFFF;
      step();
      step();
      pulse_reset();
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_bubble();
      test_mid_reset();
`ifdef EX_MEM_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
